// File: rtl/data_mem_pkg.sv
// Shared constants and helpers for the byte-addressed data memory.
// Transfer size encodings, default depth and size/alignment checks.
package data_mem_pkg;

  localparam logic [3:0] XFER_BYTE  = 4'd1;
  localparam logic [3:0] XFER_HALF  = 4'd2;
  localparam logic [3:0] XFER_WORD  = 4'd4;
  localparam logic [3:0] XFER_DWORD = 4'd8;

  localparam int DATA_MEM_DEPTH = 1024;

  localparam int LANES = 8;

  function automatic logic is_valid_xfer(
    input logic [3:0] size
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (size == XFER_BYTE):  ok = 1'b1;
      (size == XFER_HALF):  ok = 1'b1;
      (size == XFER_WORD):  ok = 1'b1;
      (size == XFER_DWORD): ok = 1'b1;
      default:              ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Sizes are powers of two, so the low three
  // address bits masked by size-1 must be zero.
  // For size 8 the 3-bit mask wraps to 3'b111.
  function automatic logic is_aligned(
    input logic [2:0] lo,
    input logic [3:0] size
  );
    logic [2:0] mask;
    mask = size[2:0] - 3'd1;
    return (lo & mask) == 3'd0;
  endfunction

endpackage

// File: rtl/data_mem_byte_en.sv
// Lane generator: maps (address low bits, size, enable) to 8 byte lanes.
// Ports: addr_lo_i, xfer_size_i, en_i -> lane_idx_o[8], lane_en_o[8].
// Optional DATAMEM_ALIGN_CHECK_EN kills all lanes on misaligned access.
module data_mem_byte_en
  import data_mem_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic [AW-1:0]         addr_lo_i,
  input  logic [3:0]            xfer_size_i,
  input  logic                  en_i,
  output logic [7:0][AW-1:0]    lane_idx_o,
  output logic [LANES-1:0]      lane_en_o
);

  logic ok;

  always_comb begin
    ok = en_i && is_valid_xfer(xfer_size_i);
`ifdef DATAMEM_ALIGN_CHECK_EN
    ok = ok && is_aligned(addr_lo_i[2:0], xfer_size_i);
`endif
    lane_idx_o = '0;
    lane_en_o  = '0;
    for (int k = 0; k < LANES; k++) begin
      // Index arithmetic is AW bits wide, so it
      // wraps modulo the memory depth for free.
      lane_idx_o[k] = addr_lo_i + AW'(k);
      lane_en_o[k]  = ok && (4'(k) < xfer_size_i);
    end
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory, 1/2/4/8-byte transfers.
// Ports: clk, rst_n, address, write_enable, read_enable, write_data,
//        xfer_size -> read_data (zero-extended, combinational).
// Optional macro DATAMEM_ALIGN_CHECK_EN: misaligned accesses are dropped.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = DATA_MEM_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] address,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [63:0] write_data,
  input  logic [3:0]  xfer_size,
  output logic [63:0] read_data
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]          mem_q [DEPTH_BYTES];
  logic [7:0][AW-1:0]  lane_idx;
  logic [LANES-1:0]    lane_en;
  logic [63:0]         rdata_d;
  logic                unused_addr_hi;

  // Upper address bits are ignored: accesses
  // wrap modulo the memory depth.
  assign unused_addr_hi = ^address[63:AW];

  // One lane map serves both the read and
  // write paths; each path gates it separately.
  data_mem_byte_en #(
    .AW(AW)
  ) u_byte_en (
    .addr_lo_i   (address[AW-1:0]),
    .xfer_size_i (xfer_size),
    .en_i        (read_enable | write_enable),
    .lane_idx_o  (lane_idx),
    .lane_en_o   (lane_en)
  );

  // Lanes always hit distinct bytes since at
  // most 8 lanes are live and depth >= 8.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_enable) begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_en[k]) begin
          mem_q[lane_idx[k]] <= write_data[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (read_enable && rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_en[k]) begin
          rdata_d[8*k +: 8] = mem_q[lane_idx[k]];
        end
      end
    end
  end

  assign read_data = rdata_d;

`ifdef DATAMEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst_n && (read_enable || write_enable)
        && is_valid_xfer(xfer_size)
        && !is_aligned(address[2:0], xfer_size)) begin
      $error("data_mem: misaligned access addr=%h size=%0d",
             address, xfer_size);
    end
  end
`endif

endmodule

// File: tb/tb_data_mem.sv
// Randomised bench for data_mem against a byte-array reference model.
// Directed cases cover round trip, endianness, sizes, reset and wrap.
module tb_data_mem;

  localparam int D = 1024;

  logic        clk;
  logic        rst_n;
  logic [63:0] address;
  logic        write_enable;
  logic        read_enable;
  logic [63:0] write_data;
  logic [3:0]  xfer_size;
  logic [63:0] read_data;

  logic [7:0]  ref_mem [D];
  int          n_checks;
  int          n_pass;

  data_mem #(
    .DEPTH_BYTES(D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .address      (address),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .write_data   (write_data),
    .xfer_size    (xfer_size),
    .read_data    (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  function automatic bit size_ok(input logic [3:0] sz);
    return sz == 1 || sz == 2 || sz == 4 || sz == 8;
  endfunction

  function automatic bit access_ok(
    input logic [63:0] a,
    input logic [3:0]  sz
  );
    if (!size_ok(sz)) return 0;
`ifdef DATAMEM_ALIGN_CHECK_EN
    if ((a % sz) != 0) return 0;
`endif
    return 1;
  endfunction

  function automatic logic [63:0] m_read(
    input logic [63:0] a,
    input logic [3:0]  sz,
    input logic        re
  );
    logic [63:0] r;
    int base;
    r = 0;
    if (!re || !access_ok(a, sz)) return 0;
    base = int'(a % D);
    for (int k = 0; k < int'(sz); k++)
      r = r | (64'(ref_mem[(base + k) % D]) << (8 * k));
    return r;
  endfunction

  task automatic m_write(
    input logic [63:0] a,
    input logic [3:0]  sz,
    input logic [63:0] wd
  );
    int base;
    if (!access_ok(a, sz)) return;
    base = int'(a % D);
    for (int k = 0; k < int'(sz); k++)
      ref_mem[(base + k) % D] = wd[8*k +: 8];
  endtask

  task automatic m_clear();
    for (int i = 0; i < D; i++) ref_mem[i] = 8'h00;
  endtask

  // Called just after a rising edge: drive, check the
  // pre-edge read, clock, then check the post-edge read.
  task automatic op(
    input logic [63:0] a,
    input logic [3:0]  sz,
    input logic        we,
    input logic        re,
    input logic [63:0] wd,
    input string       tag
  );
    address      = a;
    xfer_size    = sz;
    write_enable = we;
    read_enable  = re;
    write_data   = wd;
    #2;
    check({tag, "_pre"}, read_data, m_read(a, sz, re));
    @(posedge clk);
    if (we) m_write(a, sz, wd);
    #1;
    check({tag, "_post"}, read_data, m_read(a, sz, re));
  endtask

  logic [7:0]  exp_b [7];
  logic [7:0]  wrap_b [4];
  logic [63:0] wrap_w;
  logic [63:0] ra;
  logic [3:0]  rs;
  int          pick;

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    address      = '0;
    write_enable = 1'b0;
    read_enable  = 1'b1;
    write_data   = '0;
    xfer_size    = 4'd8;
    m_clear();

    // Writes during reset must not land.
    #3;
    check("rst_rd", read_data, 64'h0);
    write_enable = 1'b1;
    write_data   = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    check("rst_wr_blocked", read_data, 64'h0);
    @(negedge clk);
    write_enable = 1'b0;
    rst_n        = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_rd", read_data, 64'h0);

    op(0, 8, 1, 1, 64'hDEADBEEFCAFEF00D, "dw_rt");
    check("dw_const", read_data, 64'hDEADBEEFCAFEF00D);

    exp_b = '{8'hF0, 8'hFE, 8'hCA, 8'hEF,
              8'hBE, 8'hAD, 8'hDE};
    for (int k = 1; k < 8; k++) begin
      op(64'(k), 1, 0, 1, 0, "le_byte");
      check("le_const", read_data, {56'h0, exp_b[k-1]});
    end

    op(1, 1, 1, 0, 64'h0000_0000_0000_00AB, "b_wr");
    op(0, 8, 0, 1, 0, "b_iso");
    check("b_iso_const", read_data, 64'hDEADBEEFCAFEAB0D);

    op(8, 8, 1, 0, 64'h1122334455667788, "sz_wr");
    op(8, 4, 0, 1, 0, "w_rd");
    check("w_const", read_data, 64'h0000000055667788);
    op(12, 2, 0, 1, 0, "h_rd");
    check("h_const", read_data, 64'h0000000000003344);

    op(0, 8, 0, 0, 0, "re0");
    check("re0_const", read_data, 64'h0);

    op(0, 3, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, "bad_sz");
    check("bad_sz_rd", read_data, 64'h0);
    op(0, 8, 0, 1, 0, "bad_sz_keep");
    check("bad_sz_const", read_data, 64'hDEADBEEFCAFEAB0D);

    op(D - 2, 4, 1, 0, 64'hA1B2C3D4, "wrap_wr");
`ifdef DATAMEM_ALIGN_CHECK_EN
    wrap_b = '{8'h00, 8'h00, 8'h0D, 8'hAB};
    wrap_w = 64'h0;
`else
    wrap_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    wrap_w = 64'hA1B2C3D4;
`endif
    for (int k = 0; k < 4; k++) begin
      op(64'((D - 2 + k) % D), 1, 0, 1, 0, "wrap_b");
      check("wrap_b_const", read_data, {56'h0, wrap_b[k]});
    end
    op(D - 2, 4, 0, 1, 0, "wrap_w");
    check("wrap_w_const", read_data, wrap_w);

    // Async reset mid-cycle, away from any edge.
    address      = 0;
    xfer_size    = 8;
    read_enable  = 1'b1;
    write_enable = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", read_data, 64'h0);
    m_clear();
    #2;
    rst_n = 1'b1;
    #1;
    check("async_rst_rel", read_data, 64'h0);
    @(posedge clk);
    #1;
    op(8, 8, 0, 1, 0, "rst_cleared");
    check("rst_cleared_const", read_data, 64'h0);

    for (int i = 0; i < 400; i++) begin
      pick = int'($urandom_range(0, 9));
      if (pick < 6)      ra = 64'($urandom_range(0, 47));
      else if (pick < 8) ra = 64'(D - 8 + $urandom_range(0, 7));
      else               ra = {$urandom, $urandom};
      if ($urandom_range(0, 9) < 8)
        rs = 4'(1 << $urandom_range(0, 3));
      else
        rs = 4'($urandom_range(0, 15));
      op(ra, rs, 1'($urandom), 1'($urandom),
         {$urandom, $urandom}, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
